// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mult_arbiter_pkg
// Description : Shared defaults for the multiplier arbiter and a width helper
//               used for tag and occupancy counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_A_WIDTH   = 8;
  localparam int DEF_B_WIDTH   = 8;
  localparam int DEF_A_FRAC    = 0;
  localparam int DEF_B_FRAC    = 0;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_OUT_FRAC  = 0;
  localparam int DEF_DELAY     = 3;

  // Bits needed to encode values 0..value-1; never less than one so a
  // single-requester or single-stage build still has a legal vector.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_mult.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_mult
// Description : Pipelined unsigned fixed-point multiplier. The product is
//               rescaled to the output fraction, truncated, and carried
//               through DELAY stages. hold freezes every stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter_mult #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int A_FRAC    = 0,
  parameter int B_FRAC    = 0,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 0,
  parameter int DELAY     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 hold,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic [OUT_WIDTH-1:0] p,
  output logic                 done
);

  // Wide enough for the full product plus any left shift that still lands
  // inside the output window.
  localparam int PROD_W = A_WIDTH + B_WIDTH + OUT_WIDTH;
  localparam int SHIFT  = A_FRAC + B_FRAC - OUT_FRAC;

  logic [PROD_W-1:0]                product;
  logic [OUT_WIDTH-1:0]             scaled;
  logic [DELAY-1:0]                 valid_pipe;
  logic [DELAY-1:0][OUT_WIDTH-1:0]  data_pipe;

  assign product = PROD_W'(a) * PROD_W'(b);

  generate
    if (SHIFT >= 0) begin : g_shift_right
      assign scaled = OUT_WIDTH'(product >> SHIFT);
    end else begin : g_shift_left
      assign scaled = OUT_WIDTH'(product << (-SHIFT));
    end
  endgenerate

  // Advance valid and data together; a data stage only loads behind a valid
  // entry so the final stage keeps the last result between operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pipe <= '0;
      data_pipe  <= '0;
    end else if (!hold) begin
      valid_pipe[0] <= en;
      if (en) data_pipe[0] <= scaled;
      for (int k = 1; k < DELAY; k++) begin
        valid_pipe[k] <= valid_pipe[k-1];
        if (valid_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
      end
    end
  end

  assign p    = data_pipe[DELAY-1];
  assign done = valid_pipe[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Shares one pipelined multiplier among NUM_REQ requesters with
//               round-robin issue, a requester tag pipeline that follows the
//               multiplier, and response back-pressure that freezes both.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int A_FRAC    = DEF_A_FRAC,
  parameter int B_FRAC    = DEF_B_FRAC,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int OUT_FRAC  = DEF_OUT_FRAC,
  parameter int DELAY     = DEF_DELAY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [OUT_WIDTH-1:0]         resp_data,
  output logic                         busy,
  output logic [clog2(DELAY+1)-1:0]    in_flight
);

  localparam int TAG_W  = clog2(NUM_REQ);
  localparam int CAND_W = TAG_W + 1;
  localparam int CNT_W  = clog2(DELAY+1);

  logic [TAG_W-1:0]             last_grant;
  logic [TAG_W-1:0]             sel_idx;
  logic                         sel_found;
  logic [CAND_W-1:0]            cand;
  logic                         grant_ok;
  logic                         stall;
  logic                         resp_fire;
  logic                         reset_q;
  logic [A_WIDTH-1:0]           op_a;
  logic [B_WIDTH-1:0]           op_b;
  logic [OUT_WIDTH-1:0]         mul_p;
  logic                         mul_done;
  logic [DELAY-1:0][TAG_W-1:0]  tag_pipe;
  logic [TAG_W-1:0]             tag_out;

  assign tag_out   = tag_pipe[DELAY-1];
  assign stall     = mul_done & ~resp_ready[tag_out];
  assign resp_fire = mul_done &  resp_ready[tag_out];
  // Issue is also blocked in the cycle right after reset so every output
  // is quiet for that cycle.
  assign grant_ok  = sel_found & ~stall & ~reset & ~reset_q;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + CAND_W'(k);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!sel_found && req_valid[cand[TAG_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[TAG_W-1:0];
      end
    end
  end

  // Steer the selected requester's operands and decode grants/responses.
  always_comb begin
    op_a       = '0;
    op_b       = '0;
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == TAG_W'(i)) begin
        op_a = req_a[i*A_WIDTH +: A_WIDTH];
        op_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
      req_ready[i]  = grant_ok && (sel_idx == TAG_W'(i));
      resp_valid[i] = !reset && mul_done && (tag_out == TAG_W'(i));
    end
  end

  assign resp_data = reset ? '0 : mul_p;
  assign busy      = !reset && (in_flight != '0);

  // Remember the last winner and the previous cycle's reset.
  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) last_grant <= TAG_W'(NUM_REQ - 1);
    else if (grant_ok) last_grant <= sel_idx;
  end

  // Requester tags shadow the multiplier stages and freeze with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe <= '0;
    end else if (!stall) begin
      tag_pipe[0] <= sel_idx;
      for (int k = 1; k < DELAY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Occupancy: issues in, accepted responses out.
  always_ff @(posedge clk) begin
    if (reset) in_flight <= '0;
    else if (grant_ok && !resp_fire) in_flight <= in_flight + CNT_W'(1);
    else if (!grant_ok && resp_fire) in_flight <= in_flight - CNT_W'(1);
  end

  mult_arbiter_mult #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .A_FRAC    (A_FRAC),
    .B_FRAC    (B_FRAC),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_FRAC  (OUT_FRAC),
    .DELAY     (DELAY)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .en    (grant_ok),
    .hold  (stall),
    .a     (op_a),
    .b     (op_b),
    .p     (mul_p),
    .done  (mul_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Directed and random checks of mult_arbiter against an
//               issue-queue reference model, plus a fixed-point DELAY=1 copy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] resp_data;
  logic        busy;
  logic [1:0]  in_flight;

  logic        fx_reset;
  logic [3:0]  fx_req_valid, fx_req_ready, fx_resp_valid, fx_resp_ready;
  logic [31:0] fx_req_a, fx_req_b;
  logic [15:0] fx_resp_data;
  logic        fx_busy;
  logic [0:0]  fx_in_flight;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int idx; int data; int age; } op_t;
  op_t         q[$];
  int          m_last = N - 1;
  logic [15:0] m_data = '0;
  bit          m_post = 1'b0;

  always #5 clk = ~clk;

  mult_arbiter u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy),
    .in_flight(in_flight)
  );

  mult_arbiter #(.A_FRAC(4), .B_FRAC(4), .OUT_FRAC(4), .DELAY(1)) u_fx (
    .clk(clk), .reset(fx_reset), .req_valid(fx_req_valid),
    .req_ready(fx_req_ready), .req_a(fx_req_a), .req_b(fx_req_b),
    .resp_valid(fx_resp_valid), .resp_ready(fx_resp_ready),
    .resp_data(fx_resp_data), .busy(fx_busy), .in_flight(fx_in_flight)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  function automatic int prod(input int i);
    return (int'(req_a[i*8 +: 8]) * int'(req_b[i*8 +: 8])) & 16'hFFFF;
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
  endtask

  // Reference: queue of issued ops in order, each aging one step per
  // non-stalled cycle; the head responds once it has aged DELAY steps.
  task automatic main_check();
    bit          due;
    bit          stl;
    int          g;
    logic [3:0]  exp_rv;
    logic [15:0] exp_data;
    op_t         e;
    due = (q.size() > 0) && (q[0].age == D);
    stl = due && !resp_ready[q[0].idx];
    exp_rv = 4'b0;
    exp_data = m_data;
    if (due) begin
      exp_rv = oh(q[0].idx);
      exp_data = 16'(q[0].data);
    end
    g = -1;
    if (!reset && !m_post && !stl)
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
    if (reset) begin
      exp_rv = 4'b0;
      exp_data = '0;
    end
    chk("req_ready", req_ready, (g >= 0) ? oh(g) : 4'b0);
    chk("resp_valid", resp_valid, exp_rv);
    chk("resp_data", resp_data, exp_data);
    chk("busy", busy, !reset && (q.size() != 0));
    chk("in_flight", in_flight, q.size());
    if (reset) begin
      q.delete();
      m_last = N - 1;
      m_data = '0;
      m_post = 1'b1;
    end else begin
      m_post = 1'b0;
      if (due) m_data = 16'(q[0].data);
      if (!stl) begin
        if (due) q.delete(0);
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (g >= 0) begin
          e.idx = g; e.data = prod(g); e.age = 1;
          q.push_back(e);
          m_last = g;
        end
      end
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    main_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prods[4];
    int fa[4];
    int fb[4];
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 4'hF;
    fx_reset = 1'b1; fx_req_valid = '0; fx_req_a = '0; fx_req_b = '0;
    fx_resp_ready = 4'hF;

    // Reset state
    tick_check(); chk("rst_in_flight", in_flight, 2'd0); advance();
    tick_check(); advance();
    reset = 1'b0; fx_reset = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < N; i++) set_ops(i, i + 3, (i + 1) * 10);
    prods = '{30, 80, 150, 240};
    tick_check(); chk("post_rst_ready", req_ready, 4'b0); advance();

    // Contention: grants 0,1,2,3,0 and results routed back DELAY later
    for (int j = 0; j < 8; j++) begin
      if (j == 5) req_valid = '0;
      tick_check();
      if (j < 5) chk("rr_grant", req_ready, oh(j % 4));
      if (j >= 3) begin
        chk("rr_resp_valid", resp_valid, oh((j - 3) % 4));
        chk("rr_resp_data", resp_data, 16'(prods[(j - 3) % 4]));
      end
      advance();
    end

    // Single op from requester 2
    req_valid = 4'b0100; set_ops(2, 7, 6);
    tick_check(); chk("single_ready", req_ready, 4'b0100); advance();
    req_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      tick_check();
      chk("single_busy", busy, 1'b1);
      if (c == 3) begin
        chk("single_valid", resp_valid, 4'b0100);
        chk("single_data", resp_data, 16'd42);
      end
      advance();
    end
    tick_check(); chk("single_idle", busy, 1'b0); advance();

    // Back-pressure on requester 1
    set_ops(1, 9, 11); set_ops(2, 5, 5); set_ops(3, 12, 12); set_ops(0, 2, 50);
    req_valid = 4'b0010; tick_check(); advance();
    req_valid = 4'b0100; tick_check(); advance();
    req_valid = 4'b1000; tick_check(); advance();
    req_valid = 4'b0001; resp_ready = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      tick_check();
      chk("bp_ready", req_ready, 4'b0);
      chk("bp_valid", resp_valid, 4'b0010);
      chk("bp_data", resp_data, 16'd99);
      advance();
    end
    resp_ready = 4'hF;
    tick_check(); chk("bp_release", req_ready, 4'b0001); advance();
    req_valid = '0;
    tick_check(); chk("bp_next2", resp_valid, 4'b0100); chk("bp_data2", resp_data, 16'd25); advance();
    tick_check(); chk("bp_next3", resp_valid, 4'b1000); chk("bp_data3", resp_data, 16'd144); advance();
    tick_check(); chk("bp_next0", resp_valid, 4'b0001); chk("bp_data0", resp_data, 16'd100); advance();

    // Reset with operations in flight
    req_valid = 4'hF;
    tick_check(); advance();
    tick_check(); advance();
    reset = 1'b1; tick_check(); chk("mid_rst_ready", req_ready, 4'b0); advance();
    reset = 1'b0;
    tick_check(); chk("mid_rst_flight", in_flight, 2'd0); chk("mid_rst_rv", resp_valid, 4'b0); advance();
    tick_check(); chk("mid_rst_grant0", req_ready, 4'b0001); advance();
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      tick_check(); chk("mid_rst_quiet", resp_valid, 4'b0); advance();
    end
    tick_check(); chk("mid_rst_new", resp_valid, 4'b0001); chk("mid_rst_data", resp_data, 16'd100); advance();

    // Random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      resp_ready = 4'($urandom) | 4'($urandom);
      tick_check();
      advance();
    end
    reset = 1'b0; req_valid = '0; resp_ready = 4'hF;
    for (int c = 0; c < 12; c++) begin
      tick_check(); advance();
    end

    // Fixed point, DELAY=1, back-to-back from requester 0
    fa = '{8'h18, 8'h10, 8'hFF, 8'h33};
    fb = '{8'h20, 8'h08, 8'hFF, 8'h47};
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        fx_req_valid = 4'b0001;
        fx_req_a = {24'h0, 8'(fa[j])};
        fx_req_b = {24'h0, 8'(fb[j])};
      end else begin
        fx_req_valid = '0;
      end
      tick_check();
      if (j < 4) chk("fx_ready", fx_req_ready, 4'b0001);
      if (j >= 1 && j <= 4) begin
        chk("fx_valid", fx_resp_valid, 4'b0001);
        chk("fx_data", fx_resp_data, 16'((fa[j-1] * fb[j-1]) >> 4));
        chk("fx_flight", fx_in_flight, 1'b1);
      end
      if (j == 1) chk("fx_fixed_point", fx_resp_data, 16'h0030);
      if (j == 0 || j == 5) chk("fx_flight_idle", fx_in_flight, 1'b0);
      if (j == 5) chk("fx_valid_done", fx_resp_valid, 4'b0);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
